uart_line_assembler: RTL

Consumes received characters from the UART receiver's `rx_req`/`rx_ready` byte handshake and assembles them into complete text lines terminated by CR or LF. A finished line is held in an internal buffer and presented to the command/response parser through a valid/ready handshake and a random-access read port. The block sits directly downstream of the UART receiver on the modem console path.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_line_ram.sv | 42 ++++
 rtl/uart_line_assembler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared character constants and line-assembler state type
package uart_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_DEL = 8'h7F;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    DONE    = 2'd2
  } line_state_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF);
  endfunction

  function automatic logic is_erase(input logic [7:0] c);
    return (c == CHAR_BS) || (c == CHAR_DEL);
  endfunction

endpackage

// File: rtl/uart_line_ram.sv
// rtl/uart_line_ram.sv - DEPTH x 8 simple dual-port line buffer, registered read
// Ports: clk, reset (async, active-high, clears read register only),
//        wr_en/wr_addr/wr_data (synchronous write), rd_addr -> rd_data (1-cycle latency).
module uart_line_ram #(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  // Storage carries no reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_line_assembler.sv
// rtl/uart_line_assembler.sv - assembles UART characters into CR/LF terminated lines
// Ports: clk, reset (async, active-high);
//        rx_req/rx_ready/rx_data/rx_error : character input handshake;
//        line_valid/line_ready/line_len/line_err : held-line handshake;
//        rd_addr -> rd_data : registered random-access read of the held line.
// Build option: UART_LINE_BACKSPACE_EN makes BS/DEL erase the last stored char.
module uart_line_assembler
  import uart_pkg::*;
#(
  parameter  int MAX_LEN = 64,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_req,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_error,
  output logic              line_valid,
  input  logic              line_ready,
  output logic [LEN_W-1:0]  line_len,
  output logic              line_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  line_state_t      state_q,    state_d;
  logic [LEN_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic             err_acc_q,  err_acc_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic             line_err_q, line_err_d;
  logic             rx_ready_q, rx_ready_d;

  logic              rx_fire;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;

  assign rx_fire = rx_req && rx_ready_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    err_acc_d  = err_acc_q;
    line_len_d = line_len_q;
    line_err_d = line_err_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr_q[ADDR_W-1:0];

    case (state_q)
      COLLECT: begin
        if (rx_fire) begin
          if (is_term(rx_data)) begin
            // A terminator with nothing collected is swallowed, so CRLF yields one line.
            if (wr_ptr_q != '0) begin
              line_len_d = wr_ptr_q;
              line_err_d = err_acc_q | rx_error;
              state_d    = DONE;
            end
          end
`ifdef UART_LINE_BACKSPACE_EN
          else if (is_erase(rx_data)) begin
            if (wr_ptr_q != '0) begin
              wr_ptr_d = wr_ptr_q - LEN_W'(1);
            end
          end
`endif
          else if (wr_ptr_q == FULL) begin
            err_acc_d = 1'b1;
            state_d   = DISCARD;
          end else begin
            ram_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + LEN_W'(1);
            err_acc_d = err_acc_q | rx_error;
          end
        end
      end

      DISCARD: begin
        // Buffer already holds MAX_LEN chars; wait for the terminator and hand it over truncated.
        if (rx_fire && is_term(rx_data)) begin
          line_len_d = FULL;
          line_err_d = 1'b1;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (line_ready) begin
          wr_ptr_d  = '0;
          err_acc_d = 1'b0;
          state_d   = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase

    // Registered back-pressure: drop rx_ready in the same cycle the line becomes held.
    rx_ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      wr_ptr_q   <= '0;
      err_acc_q  <= 1'b0;
      line_len_q <= '0;
      line_err_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      err_acc_q  <= err_acc_d;
      line_len_q <= line_len_d;
      line_err_q <= line_err_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  uart_line_ram #(
    .DEPTH(MAX_LEN)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(rx_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign rx_ready   = rx_ready_q;
  assign line_valid = (state_q == DONE);
  assign line_len   = line_len_q;
  assign line_err   = line_err_q;

endmodule
